// File: rtl/counter_sched_ctrl.sv
// Round-robin scheduler that lends one shared counter to NUM_REQ requesters,
// clearing it, running it up to the owner's delay and pulsing that owner's done.
module counter_sched_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 6
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_delay,
  input  logic                     abort,
  input  logic [CNT_W-1:0]         cnt_val,
  output logic                     cnt_en,
  output logic                     cnt_clr,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   dly_q, dly_d;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic               match;
  logic [NUM_REQ-1:0] owner_oh;

  assign match    = (cnt_val == dly_q);
  assign owner_oh = NUM_REQ'(1) << owner_q;

  // First set request after rr_ptr, wrapping around.
  always_comb begin
    logic [IDX_W-1:0] idx;
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    dly_d    = dly_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_LOAD;
          owner_d  = pick;
          rr_ptr_d = pick;
          dly_d    = req_delay[int'(pick)*CNT_W +: CNT_W];
        end
      end
      S_LOAD: state_d = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (match) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    grant   = '0;
    done    = '0;
    busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        cnt_clr = 1'b1;
        grant   = owner_oh;
      end
      S_RUN: begin
        grant   = owner_oh;
        cnt_clr = abort;
        cnt_en  = !abort && !match;
      end
      S_DONE: begin
        grant = owner_oh;
        done  = owner_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      owner_q  <= '0;
      dly_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      dly_q    <= dly_d;
    end
  end

endmodule

// File: tb/tb_counter_sched_ctrl.sv
// Bench for counter_sched_ctrl: models the shared counter and scoreboards
// every done pulse (owner and cycle) against expectations queued at stimulus time.
module tb_counter_sched_ctrl;

  localparam int NR = 4;
  localparam int CW = 6;

  typedef struct {
    int owner;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*CW-1:0] req_delay = '0;
  logic             abort = 1'b0;
  logic [CW-1:0]    cnt_val = '0;
  logic             cnt_en, cnt_clr, busy;
  logic [NR-1:0]    grant, done;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  counter_sched_ctrl #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .req_delay(req_delay),
    .abort    (abort),
    .cnt_val  (cnt_val),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .grant    (grant),
    .done     (done),
    .busy     (busy)
  );

  // Shared counter as the scheduler expects it to behave.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_clr) cnt_val <= '0;
    else if (cnt_en) cnt_val <= cnt_val + 1'b1;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done != '0) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", longint'(done), 0);
      end else begin
        e = sb.pop_front();
        chk("done_owner", longint'(done), longint'(1) << e.owner);
        chk("done_cycle", longint'(cyc), longint'(e.cyc));
        chk("done_grant", longint'(grant), longint'(done));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int c);
    while (cyc < c) step();
  endtask

  task automatic at(input int c);
    go(c);
    @(negedge clk);
  endtask

  task automatic set_d(input int i, input int d);
    req_delay[i*CW +: CW] = CW'(d);
  endtask

  task automatic do_reset();
    clr   = 1'b1;
    req   = '0;
    abort = 1'b0;
    step();
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("rst_grant", longint'(grant), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_en", longint'(cnt_en), 0);
    chk("rst_clr", longint'(cnt_clr), 0);
    step();
  endtask

  initial begin
    // 1: single request, D=5
    do_reset();
    t = cyc;
    set_d(0, 5);
    req = 4'b0001;
    sb.push_back('{0, t + 8});
    at(t + 1);
    chk("t1_grant", longint'(grant), 1);
    chk("t1_load_clr", longint'(cnt_clr), 1);
    chk("t1_busy", longint'(busy), 1);
    req = '0;
    at(t + 2);
    chk("t1_run0_val", longint'(cnt_val), 0);
    chk("t1_run0_en", longint'(cnt_en), 1);
    at(t + 7);
    chk("t1_match_val", longint'(cnt_val), 5);
    chk("t1_match_en", longint'(cnt_en), 0);
    at(t + 9);
    chk("t1_idle_busy", longint'(busy), 0);

    // 2: all four requesting, D=2, round-robin from reset
    do_reset();
    t = cyc;
    for (int i = 0; i < NR; i++) set_d(i, 2);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) sb.push_back('{k % 4, t + 6*k + 5});
    for (int k = 0; k < 5; k++) begin
      at(t + 6*k + 1);
      chk("t2_grant", longint'(grant), longint'(1) << (k % 4));
    end
    req = '0;
    at(t + 31);
    chk("t2_idle_busy", longint'(busy), 0);

    // 3: D=0 gives a single RUN cycle
    step();
    t = cyc;
    set_d(0, 0);
    req = 4'b0001;
    sb.push_back('{0, t + 3});
    at(t + 1);
    req = '0;
    at(t + 2);
    chk("t3_run_en", longint'(cnt_en), 0);
    chk("t3_run_busy", longint'(busy), 1);
    chk("t3_run_val", longint'(cnt_val), 0);
    at(t + 4);
    chk("t3_end_val", longint'(cnt_val), 0);
    chk("t3_end_busy", longint'(busy), 0);

    // 4: full-scale delay, no wrap
    step();
    t = cyc;
    set_d(1, 63);
    req = 4'b0010;
    sb.push_back('{1, t + 66});
    at(t + 1);
    chk("t4_grant", longint'(grant), 2);
    req = '0;
    at(t + 64);
    chk("t4_pre_val", longint'(cnt_val), 62);
    chk("t4_pre_en", longint'(cnt_en), 1);
    at(t + 65);
    chk("t4_match_val", longint'(cnt_val), 63);
    chk("t4_match_en", longint'(cnt_en), 0);
    at(t + 67);
    chk("t4_hold_val", longint'(cnt_val), 63);
    chk("t4_idle_busy", longint'(busy), 0);

    // 5: abort on third RUN cycle, then requester 2
    step();
    t = cyc;
    set_d(0, 10);
    req = 4'b0001;
    at(t + 1);
    chk("t5_grant", longint'(grant), 1);
    req = '0;
    go(t + 4);
    abort = 1'b1;
    @(negedge clk);
    chk("t5_abort_val", longint'(cnt_val), 2);
    chk("t5_abort_clr", longint'(cnt_clr), 1);
    chk("t5_abort_en", longint'(cnt_en), 0);
    chk("t5_abort_done", longint'(done), 0);
    go(t + 5);
    abort = 1'b0;
    set_d(2, 3);
    req = 4'b0100;
    sb.push_back('{2, t + 11});
    @(negedge clk);
    chk("t5_idle_busy", longint'(busy), 0);
    chk("t5_idle_val", longint'(cnt_val), 0);
    at(t + 6);
    chk("t5_grant2", longint'(grant), 4);
    req = '0;
    at(t + 12);
    chk("t5_end_busy", longint'(busy), 0);

    // 6: clr with abort mid-RUN, rr_ptr back to favouring req0
    step();
    t = cyc;
    set_d(1, 10);
    req = 4'b0010;
    at(t + 1);
    chk("t6_grant", longint'(grant), 2);
    req = '0;
    go(t + 4);
    clr   = 1'b1;
    abort = 1'b1;
    go(t + 5);
    clr   = 1'b0;
    abort = 1'b0;
    set_d(0, 1);
    set_d(3, 1);
    req = 4'b1001;
    sb.push_back('{0, t + 9});
    @(negedge clk);
    chk("t6_rst_grant", longint'(grant), 0);
    chk("t6_rst_done", longint'(done), 0);
    chk("t6_rst_busy", longint'(busy), 0);
    chk("t6_rst_en", longint'(cnt_en), 0);
    chk("t6_rst_clr", longint'(cnt_clr), 0);
    at(t + 6);
    chk("t6_grant0", longint'(grant), 1);
    req = '0;
    at(t + 11);
    chk("t6_end_busy", longint'(busy), 0);

    chk("sb_empty", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
